baby_store: RTL and testbench
=============================

BABY_STORE -- requirements
Module: baby_store

Interface
REQ-001 Parameter: HOLD_CYCLES, default 2, minimum cycles cpu_reset_o stays high after entering LOAD or HALT before run_i is honoured (legal range 1..15).
REQ-002 Port: clock  in  1  single clock, all state on rising edge.
REQ-003 Port: reset_i  in  1  reset, asynchronous, active-high.
REQ-004 Port: cpu_addr_i  in  5  word address from CPU (ram_addr_o side).
REQ-005 Port: cpu_rw_en_i  in  1  0 = read, 1 = write.
REQ-006 Port: cpu_data_i  in  32  write data from CPU.
REQ-007 Port: cpu_data_o  out  32  read data to CPU.
REQ-008 Port: cpu_stop_lamp_i  in  1  CPU halt indication.
REQ-009 Port: cpu_reset_o  out  1  holds CPU in reset, active-high.
REQ-010 Port: run_i  in  1  start-execution request, level-sampled.
REQ-011 Port: abort_i  in  1  force stop of a running program.
REQ-012 Port: host_valid_i / host_ready_o  in/out  1/1  host request handshake.
REQ-013 Port: host_we_i, host_addr_i, host_wdata_i  in  1/5/32  host op, address, write data.
REQ-014 Port: host_rdata_o / host_rvalid_o  out  32/1  host read data and its qualifier.
REQ-015 Port: state_o  out  2  00 LOAD, 01 RUN, 10 HALT.
REQ-016 Port: run_cycles_o  out  16  clock cycles spent in RUN, saturating.

Function
REQ-017 Storage SHALL be 32 words x 32 bits, not reset, contents preserved across reset_i.
REQ-018 FSM states: LOAD, RUN, HALT; cpu_reset_o = 1 in LOAD and HALT, 0 in RUN.
REQ-019 Entry to LOAD or HALT SHALL load a hold counter with HOLD_CYCLES; counter decrements each cycle to 0.
REQ-020 LOAD -> RUN when run_i=1, host_valid_i=0 and hold counter = 0; otherwise stay.
REQ-021 HALT -> RUN under the same condition as REQ-020, with run_cycles_o cleared on that transition.
REQ-022 RUN -> HALT when cpu_stop_lamp_i=1 or abort_i=1 (either or both) on a rising edge; run_i ignored in RUN.
REQ-023 In RUN: cpu_data_o = mem[cpu_addr_i] combinationally (zero latency); write mem[cpu_addr_i] <= cpu_data_i on rising edge when cpu_rw_en_i=1.
REQ-024 Outside RUN: cpu_data_o = 0; cpu_rw_en_i ignored, no memory write from CPU side.
REQ-025 host_ready_o = 1 in LOAD and HALT, 0 in RUN; transfer occurs on edge with host_valid_i & host_ready_o.
REQ-026 Host write: mem[host_addr_i] <= host_wdata_i on the transfer edge.
REQ-027 Host read: host_rdata_o <= mem[host_addr_i] registered, host_rvalid_o pulses 1 for exactly one cycle following the transfer edge; host_rdata_o holds value until next read.
REQ-028 Host write then read of same address on consecutive transfers SHALL return the newly written data.
REQ-029 host_valid_i=1 with run_i=1 in LOAD/HALT: host op accepted, run_i ignored that cycle (host priority).
REQ-030 run_cycles_o SHALL increment by 1 every cycle in RUN, saturate at 16'hFFFF, hold in LOAD/HALT.
REQ-031 Addresses wrap naturally (5-bit); no out-of-range condition exists.

Reset
REQ-032 reset_i=1 SHALL immediately force: state LOAD, cpu_reset_o=1, host_ready_o=1, host_rvalid_o=0, host_rdata_o=0, cpu_data_o=0, run_cycles_o=0, hold counter=HOLD_CYCLES.
REQ-033 Reset asserted mid-RUN SHALL abort execution without corrupting memory except a write coincident with the reset edge, which SHALL be dropped.
REQ-034 After reset release the FSM SHALL honour run_i no earlier than HOLD_CYCLES cycles later.

Verification
REQ-035 Load: host writes 0x0000_6000 to addr 0 and 0xDEAD_BEEF to addr 31, reads both back -> rdata matches, rvalid one cycle each.
REQ-036 Start: run_i held from reset release, HOLD_CYCLES=2 -> state_o=01 and cpu_reset_o=0 on third edge after release, never earlier.
REQ-037 CPU access: in RUN, rw_en=1 addr 5 data 0x1234_5678, then rw_en=0 addr 5 -> cpu_data_o=0x1234_5678 same cycle; host_ready_o=0 throughout.
REQ-038 Halt: stop_lamp pulse after 10 RUN cycles -> state_o=10, cpu_reset_o=1, run_cycles_o=10 frozen; host readback of addr 5 returns 0x1234_5678.
REQ-039 Collision: host_valid_i and run_i together in LOAD -> host write lands, state stays LOAD; run_i next cycle -> RUN.
REQ-040 Reset mid-RUN with rw_en=1 -> write dropped, earlier contents intact, all outputs at REQ-032 values.

Source files
------------

// File: rtl/baby_store.sv
// Program store for a small CPU: 32x32 RAM shared between a host loader and the CPU,
// with a LOAD/RUN/HALT sequencer that holds the CPU in reset while the host owns the RAM.
module baby_store #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_i,
    input  logic [4:0]  cpu_addr_i,
    input  logic        cpu_rw_en_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    input  logic        cpu_stop_lamp_i,
    output logic        cpu_reset_o,
    input  logic        run_i,
    input  logic        abort_i,
    input  logic        host_valid_i,
    output logic        host_ready_o,
    input  logic        host_we_i,
    input  logic [4:0]  host_addr_i,
    input  logic [31:0] host_wdata_i,
    output logic [31:0] host_rdata_o,
    output logic        host_rvalid_o,
    output logic [1:0]  state_o,
    output logic [15:0] run_cycles_o
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

    state_t      state, state_next;
    logic [3:0]  hold, hold_next;
    logic [31:0] mem [32];
    logic        host_xfer;
    logic        cpu_we;
    logic        start;

    assign host_ready_o = (state != ST_RUN);
    assign cpu_reset_o  = (state != ST_RUN);
    assign state_o      = state;
    assign host_xfer    = host_valid_i && host_ready_o;
    assign cpu_we       = (state == ST_RUN) && cpu_rw_en_i;
    assign cpu_data_o   = (state == ST_RUN) ? mem[cpu_addr_i] : '0;

    // A pending host request outranks run_i so a load never races the CPU start.
    assign start = run_i && !host_valid_i && (hold == 4'd0);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_next = state;
        hold_next  = (hold != 4'd0) ? hold - 4'd1 : 4'd0;
        case (state)
            ST_LOAD, ST_HALT: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (cpu_stop_lamp_i || abort_i) begin
                    state_next = ST_HALT;
                    hold_next  = HOLD_INIT;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_LOAD;
            hold  <= HOLD_INIT;
        end else begin
            state <= state_next;
            hold  <= hold_next;
        end
    end

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            run_cycles_o <= '0;
        end else if (state == ST_HALT && state_next == ST_RUN) begin
            run_cycles_o <= '0;
        end else if (state == ST_RUN && run_cycles_o != 16'hFFFF) begin
            run_cycles_o <= run_cycles_o + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            host_rdata_o  <= '0;
            host_rvalid_o <= 1'b0;
        end else begin
            host_rvalid_o <= host_xfer && !host_we_i;
            if (host_xfer && !host_we_i) host_rdata_o <= mem[host_addr_i];
        end
    end

    // NOTE: the RAM has no reset so its contents survive reset_i; instead a write
    // landing on an edge while reset_i is high is suppressed explicitly.
    always_ff @(posedge clock) begin
        if (!reset_i) begin
            if (host_xfer && host_we_i) mem[host_addr_i] <= host_wdata_i;
            else if (cpu_we)            mem[cpu_addr_i]  <= cpu_data_i;
        end
    end

endmodule

// File: tb/tb_baby_store.sv
// Randomized self-checking bench for baby_store against a behavioural model
// (memory array, cycle counter and hold timing derived from the requirements).
module tb_baby_store;

    logic        clock = 1'b0;
    logic        reset_i;
    logic [4:0]  cpu_addr_i;
    logic        cpu_rw_en_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        cpu_stop_lamp_i;
    logic        cpu_reset_o;
    logic        run_i;
    logic        abort_i;
    logic        host_valid_i;
    logic        host_ready_o;
    logic        host_we_i;
    logic [4:0]  host_addr_i;
    logic [31:0] host_wdata_i;
    logic [31:0] host_rdata_o;
    logic        host_rvalid_o;
    logic [1:0]  state_o;
    logic [15:0] run_cycles_o;

    int passed = 0;
    int total  = 0;

    logic [31:0] model_mem [32];
    logic        model_running = 1'b0;
    logic [15:0] model_rc = '0;

    always #5 clock = ~clock;

    baby_store #(.HOLD_CYCLES(2)) dut (
        .clock(clock), .reset_i(reset_i),
        .cpu_addr_i(cpu_addr_i), .cpu_rw_en_i(cpu_rw_en_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .cpu_stop_lamp_i(cpu_stop_lamp_i), .cpu_reset_o(cpu_reset_o),
        .run_i(run_i), .abort_i(abort_i),
        .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
        .host_we_i(host_we_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
        .host_rdata_o(host_rdata_o), .host_rvalid_o(host_rvalid_o),
        .state_o(state_o), .run_cycles_o(run_cycles_o)
    );

    // One clock edge; the model counts every edge taken while the CPU runs.
    task automatic tick();
        @(posedge clock);
        #1;
        if (model_running && model_rc != 16'hFFFF) model_rc++;
    endtask

    task automatic host_write(input logic [4:0] a, input logic [31:0] d);
        host_valid_i = 1'b1; host_we_i = 1'b1; host_addr_i = a; host_wdata_i = d;
        tick();
        host_valid_i = 1'b0; host_we_i = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic host_read_check(input logic [4:0] a);
        logic [31:0] exp;
        exp = model_mem[a];
        host_valid_i = 1'b1; host_we_i = 1'b0; host_addr_i = a;
        tick();
        host_valid_i = 1'b0;
        total++; if (host_rvalid_o !== 1'b1) $display("FAIL rd_rvalid addr=%0d got=%b exp=1", a, host_rvalid_o); else passed++;
        total++; if (host_rdata_o !== exp) $display("FAIL rd_data addr=%0d got=%h exp=%h", a, host_rdata_o, exp); else passed++;
        tick();
        total++; if (host_rvalid_o !== 1'b0) $display("FAIL rd_rvalid_drop addr=%0d got=%b exp=0", a, host_rvalid_o); else passed++;
        total++; if (host_rdata_o !== exp) $display("FAIL rd_hold addr=%0d got=%h exp=%h", a, host_rdata_o, exp); else passed++;
    endtask

    // Asserts reset between edges, checks the immediate effect, releases after one edge.
    task automatic test_reset();
        reset_i = 1'b1;
        #1;
        model_running = 1'b0;
        model_rc      = '0;
        total++; if (state_o !== 2'b00) $display("FAIL rst_state got=%b exp=00", state_o); else passed++;
        total++; if (cpu_reset_o !== 1'b1) $display("FAIL rst_cpu_reset got=%b exp=1", cpu_reset_o); else passed++;
        total++; if (host_ready_o !== 1'b1) $display("FAIL rst_ready got=%b exp=1", host_ready_o); else passed++;
        total++; if (host_rvalid_o !== 1'b0) $display("FAIL rst_rvalid got=%b exp=0", host_rvalid_o); else passed++;
        total++; if (host_rdata_o !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", host_rdata_o); else passed++;
        total++; if (cpu_data_o !== 32'h0) $display("FAIL rst_cpu_data got=%h exp=0", cpu_data_o); else passed++;
        total++; if (run_cycles_o !== 16'h0) $display("FAIL rst_run_cycles got=%h exp=0", run_cycles_o); else passed++;
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_load();
        host_write(5'd0, 32'h0000_6000);
        host_write(5'd31, 32'hDEAD_BEEF);
        host_read_check(5'd0);
        host_read_check(5'd31);
    endtask

    // run_i held from release: RUN is reached on the third edge, not before.
    task automatic test_start();
        test_reset();
        run_i = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (e < 3) begin
                total++; if (state_o !== 2'b00 || cpu_reset_o !== 1'b1)
                    $display("FAIL start_early edge=%0d state=%b cpu_reset=%b exp=00/1", e, state_o, cpu_reset_o); else passed++;
            end
        end
        model_running = 1'b1;
        run_i = 1'b0;
        total++; if (state_o !== 2'b01) $display("FAIL start_state got=%b exp=01", state_o); else passed++;
        total++; if (cpu_reset_o !== 1'b0) $display("FAIL start_cpu_reset got=%b exp=0", cpu_reset_o); else passed++;
    endtask

    task automatic test_cpu_access();
        cpu_addr_i = 5'd5; cpu_rw_en_i = 1'b1; cpu_data_i = 32'h1234_5678;
        total++; if (host_ready_o !== 1'b0) $display("FAIL run_ready got=%b exp=0", host_ready_o); else passed++;
        tick();
        model_mem[5] = 32'h1234_5678;
        cpu_rw_en_i = 1'b0;
        #1;
        total++; if (cpu_data_o !== 32'h1234_5678) $display("FAIL cpu_read5 got=%h exp=12345678", cpu_data_o); else passed++;
        cpu_addr_i = 5'd0;
        #1;
        total++; if (cpu_data_o !== model_mem[0]) $display("FAIL cpu_read0 got=%h exp=%h", cpu_data_o, model_mem[0]); else passed++;
        cpu_addr_i = 5'd31;
        #1;
        total++; if (cpu_data_o !== model_mem[31]) $display("FAIL cpu_read31 got=%h exp=%h", cpu_data_o, model_mem[31]); else passed++;
        total++; if (host_ready_o !== 1'b0) $display("FAIL run_ready2 got=%b exp=0", host_ready_o); else passed++;
    endtask

    task automatic test_halt();
        while (model_rc < 16'd9) tick();
        total++; if (run_cycles_o !== model_rc) $display("FAIL run_count got=%0d exp=%0d", run_cycles_o, model_rc); else passed++;
        cpu_stop_lamp_i = 1'b1;
        tick();
        model_running = 1'b0;
        cpu_stop_lamp_i = 1'b0;
        total++; if (state_o !== 2'b10) $display("FAIL halt_state got=%b exp=10", state_o); else passed++;
        total++; if (cpu_reset_o !== 1'b1) $display("FAIL halt_cpu_reset got=%b exp=1", cpu_reset_o); else passed++;
        total++; if (run_cycles_o !== 16'd10) $display("FAIL halt_count got=%0d exp=10", run_cycles_o); else passed++;
        // Writes from the CPU side must be ignored while halted.
        cpu_addr_i = 5'd5; cpu_rw_en_i = 1'b1; cpu_data_i = 32'hBAD0_BAD0;
        tick(); tick();
        cpu_rw_en_i = 1'b0;
        total++; if (run_cycles_o !== 16'd10) $display("FAIL halt_frozen got=%0d exp=10", run_cycles_o); else passed++;
        total++; if (cpu_data_o !== 32'h0) $display("FAIL halt_cpu_data got=%h exp=0", cpu_data_o); else passed++;
        host_read_check(5'd5);
    endtask

    // Host request and run_i together: host wins, run honoured on the next edge.
    task automatic test_collision();
        test_reset();
        tick(); tick();
        run_i = 1'b1;
        host_write(5'd9, 32'hC0FF_EE09);
        total++; if (state_o !== 2'b00) $display("FAIL coll_state got=%b exp=00", state_o); else passed++;
        tick();
        model_running = 1'b1;
        run_i = 1'b0;
        total++; if (state_o !== 2'b01) $display("FAIL coll_run got=%b exp=01", state_o); else passed++;
        cpu_addr_i = 5'd9;
        #1;
        total++; if (cpu_data_o !== 32'hC0FF_EE09) $display("FAIL coll_data got=%h exp=c0ffee09", cpu_data_o); else passed++;
    endtask

    // Reset raised mid-RUN while a CPU write is pending: the write must not land.
    task automatic test_reset_mid_run();
        cpu_addr_i = 5'd9; cpu_rw_en_i = 1'b1; cpu_data_i = 32'h5555_AAAA;
        #1;
        test_reset();
        cpu_rw_en_i = 1'b0;
        tick();
        host_read_check(5'd9);
        host_read_check(5'd5);
    endtask

    task automatic test_back_to_back();
        logic [4:0]  a;
        logic [31:0] d;
        a = 5'($urandom);
        d = $urandom;
        host_valid_i = 1'b1; host_we_i = 1'b1; host_addr_i = a; host_wdata_i = d;
        tick();
        model_mem[a] = d;
        host_we_i = 1'b0;
        tick();
        total++; if (host_rvalid_o !== 1'b1 || host_rdata_o !== d)
            $display("FAIL b2b_wr_rd addr=%0d got=%h/%b exp=%h/1", a, host_rdata_o, host_rvalid_o, d); else passed++;
        host_addr_i = a + 5'd1;
        tick();
        host_valid_i = 1'b0;
        total++; if (host_rvalid_o !== 1'b1 || host_rdata_o !== model_mem[a + 5'd1])
            $display("FAIL b2b_rd_rd got=%h/%b exp=%h/1", host_rdata_o, host_rvalid_o, model_mem[a + 5'd1]); else passed++;
        tick();
        total++; if (host_rvalid_o !== 1'b0) $display("FAIL b2b_drop got=%b exp=0", host_rvalid_o); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 32; i++) host_write(5'(i), $urandom);
        for (int i = 0; i < 8; i++) host_read_check(5'($urandom));
        run_i = 1'b1;
        tick();
        model_running = 1'b1;
        run_i = 1'b0;
        total++; if (state_o !== 2'b01) $display("FAIL rnd_run got=%b exp=01", state_o); else passed++;
        for (int i = 0; i < 40; i++) begin
            cpu_addr_i = 5'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                cpu_rw_en_i = 1'b1; cpu_data_i = $urandom;
                tick();
                model_mem[cpu_addr_i] = cpu_data_i;
                cpu_rw_en_i = 1'b0;
            end else begin
                cpu_rw_en_i = 1'b0;
                #1;
                total++; if (cpu_data_o !== model_mem[cpu_addr_i])
                    $display("FAIL rnd_cpu_rd addr=%0d got=%h exp=%h", cpu_addr_i, cpu_data_o, model_mem[cpu_addr_i]); else passed++;
                tick();
            end
        end
        abort_i = 1'b1;
        cpu_stop_lamp_i = 1'b1;
        tick();
        model_running = 1'b0;
        abort_i = 1'b0; cpu_stop_lamp_i = 1'b0;
        total++; if (state_o !== 2'b10) $display("FAIL rnd_halt got=%b exp=10", state_o); else passed++;
        total++; if (run_cycles_o !== model_rc) $display("FAIL rnd_count got=%0d exp=%0d", run_cycles_o, model_rc); else passed++;
        for (int i = 0; i < 8; i++) host_read_check(5'($urandom));
    endtask

    // Saturating counter, HALT hold time, and the clear on HALT -> RUN.
    task automatic test_saturation();
        run_i = 1'b1;
        tick();
        model_running = 1'b1;
        run_i = 1'b0;
        repeat (65540) tick();
        total++; if (run_cycles_o !== 16'hFFFF) $display("FAIL sat_count got=%h exp=ffff", run_cycles_o); else passed++;
        abort_i = 1'b1;
        tick();
        model_running = 1'b0;
        abort_i = 1'b0;
        run_i = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            total++; if (state_o !== 2'b10) $display("FAIL halt_hold edge=%0d got=%b exp=10", e, state_o); else passed++;
        end
        total++; if (run_cycles_o !== 16'hFFFF) $display("FAIL sat_frozen got=%h exp=ffff", run_cycles_o); else passed++;
        tick();
        model_running = 1'b1;
        model_rc = '0;
        run_i = 1'b0;
        total++; if (state_o !== 2'b01) $display("FAIL rerun_state got=%b exp=01", state_o); else passed++;
        total++; if (run_cycles_o !== 16'h0) $display("FAIL rerun_clear got=%h exp=0", run_cycles_o); else passed++;
        tick(); tick(); tick();
        total++; if (run_cycles_o !== model_rc) $display("FAIL rerun_count got=%0d exp=%0d", run_cycles_o, model_rc); else passed++;
    endtask

    initial begin
        reset_i = 1'b1;
        cpu_addr_i = '0; cpu_rw_en_i = 1'b0; cpu_data_i = '0;
        cpu_stop_lamp_i = 1'b0; run_i = 1'b0; abort_i = 1'b0;
        host_valid_i = 1'b0; host_we_i = 1'b0; host_addr_i = '0; host_wdata_i = '0;
        for (int i = 0; i < 32; i++) model_mem[i] = 'x;
        @(posedge clock);
        #1;
        test_reset();
        test_load();
        test_start();
        test_cpu_access();
        test_halt();
        test_collision();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
